// File: rtl/z80fi_check_sequencer.sv
// Sequences a per-instruction formal checker over a z80fi retirement trace:
// holds it in reset while the core settles, then fires one check strobe on the target retirement.
module z80fi_check_sequencer #(
    parameter int CHECK_INSN    = 4,
    parameter int CNT_W         = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_CYCLES    = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             z80fi_valid,
    input  logic [15:0]      z80fi_reg_ip_in,
    input  logic [15:0]      z80fi_reg_ip_out,
    output logic             checker_reset,
    output logic             check,
    output logic [CNT_W-1:0] retire_count,
    output logic             done,
    output logic             timeout,
    output logic             chain_err,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        SETTLE  = 3'd1,
        COUNT   = 3'd2,
        CHECKED = 3'd3,
        TIMEOUT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TARGET      = CNT_W'(CHECK_INSN - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [15:0]      CYCLE_LAST  = 16'(MAX_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  settle_cnt;
    logic [15:0] cycle_cnt;
    logic        have_prev;
    logic [15:0] prev_ip;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign state = state_q;

    // Zero-latency strobe: the checker must see it in the same cycle the target retires.
    always_comb begin
        check = (state_q == COUNT) && z80fi_valid && (retire_count == TARGET);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= HOLD;
            checker_reset <= 1'b1;
            retire_count  <= '0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            chain_err     <= 1'b0;
            settle_cnt    <= '0;
            cycle_cnt     <= '0;
            have_prev     <= 1'b0;
            prev_ip       <= '0;
        end else begin
            case (state_q)
                HOLD: state_q <= SETTLE;
                SETTLE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                    if (settle_cnt == SETTLE_LAST) begin
                        state_q       <= COUNT;
                        checker_reset <= 1'b0;
                    end
                end
                COUNT: begin
                    cycle_cnt <= cycle_cnt + 16'd1;
                    if (z80fi_valid) begin
                        retire_count <= sat_inc(retire_count);
                        if (have_prev && (z80fi_reg_ip_in != prev_ip)) begin
                            chain_err <= 1'b1;
                        end
                        prev_ip   <= z80fi_reg_ip_out;
                        have_prev <= 1'b1;
                    end
                    // A target retirement on the last budget cycle still counts as checked.
                    if (check) begin
                        state_q <= CHECKED;
                        done    <= 1'b1;
                    end else if (cycle_cnt == CYCLE_LAST) begin
                        state_q <= TIMEOUT;
                        timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_z80fi_check_sequencer.sv
// Directed bench: instance a uses default parameters, instance b a cycle budget of 8;
// both share the same stimulus and each test checks the instance it targets.
module tb_z80fi_check_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [15:0] ip_in;
    logic [15:0] ip_out;

    logic       a_cr, a_check, a_done, a_timeout, a_chain;
    logic [7:0] a_rc;
    logic [2:0] a_state;
    logic       b_cr, b_check, b_done, b_timeout, b_chain;
    logic [7:0] b_rc;
    logic [2:0] b_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    z80fi_check_sequencer dut_a (
        .clk(clk), .reset_n(rst_n), .z80fi_valid(valid),
        .z80fi_reg_ip_in(ip_in), .z80fi_reg_ip_out(ip_out),
        .checker_reset(a_cr), .check(a_check), .retire_count(a_rc),
        .done(a_done), .timeout(a_timeout), .chain_err(a_chain), .state(a_state)
    );

    z80fi_check_sequencer #(.MAX_CYCLES(8)) dut_b (
        .clk(clk), .reset_n(rst_n), .z80fi_valid(valid),
        .z80fi_reg_ip_in(ip_in), .z80fi_reg_ip_out(ip_out),
        .checker_reset(b_cr), .check(b_check), .retire_count(b_rc),
        .done(b_done), .timeout(b_timeout), .chain_err(b_chain), .state(b_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: inputs change 1ns after the edge, outputs are sampled 1ns later.
    task automatic cyc(input logic v, input logic [15:0] i, input logic [15:0] o);
        @(posedge clk);
        #1;
        valid  = v;
        ip_in  = i;
        ip_out = o;
        #1;
    endtask

    // Reset pulse, then HOLD + two SETTLE cycles; the next cyc() is COUNT cycle 0.
    task automatic to_count();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        valid = 1'b0;
        #2;
        rst_n = 1'b1;
        cyc(1'b0, 16'h0, 16'h0);
        cyc(1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int exp_rc;
        logic v;
        rst_n  = 1'b0;
        valid  = 1'b0;
        ip_in  = 16'h0;
        ip_out = 16'h0;

        // Reset values, with valid high to show check stays low
        repeat (2) @(posedge clk);
        #1;
        valid = 1'b1;
        #1;
        chk("rst_state", a_state, 0);
        chk("rst_cr", a_cr, 1);
        chk("rst_rc", a_rc, 0);
        chk("rst_done", a_done, 0);
        chk("rst_timeout", a_timeout, 0);
        chk("rst_chain", a_chain, 0);
        chk("rst_check", a_check, 0);

        // Valid every cycle from reset release
        rst_n = 1'b1;
        #1;
        chk("t1_hold_cr", a_cr, 1);
        cyc(1'b1, 16'h0, 16'h0);
        chk("t1_settle0_state", a_state, 1);
        chk("t1_settle0_cr", a_cr, 1);
        cyc(1'b1, 16'h0, 16'h0);
        chk("t1_settle1_cr", a_cr, 1);
        chk("t1_settle1_rc", a_rc, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 16'h0, 16'h0);
            chk("t1_count_state", a_state, 2);
            chk("t1_count_cr", a_cr, 0);
            chk("t1_rc", a_rc, k);
            chk("t1_check", a_check, (k == 3) ? 1 : 0);
        end
        cyc(1'b1, 16'h0, 16'h0);
        chk("t1_done_state", a_state, 3);
        chk("t1_done", a_done, 1);
        chk("t1_done_rc", a_rc, 4);
        chk("t1_done_check", a_check, 0);
        chk("t1_done_cr", a_cr, 0);
        cyc(1'b1, 16'h0, 16'h0);
        chk("t1_rc_frozen", a_rc, 4);

        // Sparse valid pulses at COUNT cycles 0, 5, 9, 20
        to_count();
        exp_rc = 0;
        for (int c = 0; c <= 20; c++) begin
            v = (c == 0 || c == 5 || c == 9 || c == 20);
            cyc(v, 16'h0, 16'h0);
            chk("t2_check", a_check, (c == 20) ? 1 : 0);
            chk("t2_rc", a_rc, exp_rc);
            if (v) exp_rc++;
        end
        cyc(1'b0, 16'h0, 16'h0);
        chk("t2_state", a_state, 3);
        chk("t2_rc_final", a_rc, 4);
        chk("t2_done", a_done, 1);

        // IP chain break on the third retirement, sticky through done
        to_count();
        cyc(1'b1, 16'h0000, 16'h0001);
        chk("t3_chain_1st", a_chain, 0);
        cyc(1'b1, 16'h0001, 16'h0003);
        cyc(1'b1, 16'h0004, 16'h0005);
        chk("t3_chain_after2", a_chain, 0);
        cyc(1'b0, 16'h0, 16'h0);
        chk("t3_chain_after3", a_chain, 1);
        cyc(1'b1, 16'h0005, 16'h0006);
        chk("t3_check", a_check, 1);
        cyc(1'b0, 16'h0, 16'h0);
        chk("t3_done", a_done, 1);
        chk("t3_chain_sticky", a_chain, 1);

        // Wrap-around FFFF -> 0000 is a continuous chain
        to_count();
        cyc(1'b1, 16'hFFFF, 16'h0000);
        cyc(1'b1, 16'h0000, 16'h0002);
        cyc(1'b0, 16'h0, 16'h0);
        chk("t4_wrap_chain", a_chain, 0);
        chk("t4_wrap_rc", a_rc, 2);

        // Reset asserted in the same cycle as the would-be target retirement
        to_count();
        repeat (3) cyc(1'b1, 16'h0, 16'h0);
        @(posedge clk);
        #1;
        valid = 1'b1;
        #1;
        chk("t5_pre_check", a_check, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_check", a_check, 0);
        chk("t5_state", a_state, 0);
        chk("t5_cr", a_cr, 1);
        chk("t5_rc", a_rc, 0);
        chk("t5_done", a_done, 0);
        chk("t5_timeout", a_timeout, 0);
        chk("t5_chain", a_chain, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        valid = 1'b0;
        cyc(1'b0, 16'h0, 16'h0);
        cyc(1'b0, 16'h0, 16'h0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 16'h0, 16'h0);
            chk("t5_restart_check", a_check, (k == 3) ? 1 : 0);
        end
        cyc(1'b0, 16'h0, 16'h0);
        chk("t5_restart_done", a_done, 1);
        chk("t5_restart_rc", a_rc, 4);

        // Budget of 8 cycles with only two retirements
        to_count();
        for (int c = 0; c < 8; c++) begin
            cyc((c == 1 || c == 3), 16'h0, 16'h0);
            chk("t6_check", b_check, 0);
            chk("t6_state", b_state, 2);
        end
        cyc(1'b1, 16'h0, 16'h0);
        chk("t6_to_state", b_state, 4);
        chk("t6_timeout", b_timeout, 1);
        chk("t6_done", b_done, 0);
        chk("t6_to_check", b_check, 0);
        chk("t6_to_cr", b_cr, 0);
        cyc(1'b0, 16'h0, 16'h0);
        chk("t6_rc_frozen", b_rc, 2);

        // Fourth retirement on the last budget cycle: check beats timeout
        to_count();
        for (int c = 0; c < 8; c++) begin
            cyc((c >= 4), 16'h0, 16'h0);
            chk("t7_check", b_check, (c == 7) ? 1 : 0);
        end
        cyc(1'b0, 16'h0, 16'h0);
        chk("t7_state", b_state, 3);
        chk("t7_done", b_done, 1);
        chk("t7_timeout", b_timeout, 0);
        chk("t7_rc", b_rc, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/z80fi_check_sequencer.md
Name: z80fi_check_sequencer

Overview:
Sequences the per-instruction formal checker across a trace. It holds the checker in reset until the core has settled after reset, then counts z80fi retirements. On exactly the CHECK_INSN-th retirement it asserts a single-cycle check strobe. It also flags IP discontinuities between consecutive retirements and a watchdog timeout when the target retirement never arrives.

Parameters:
CHECK_INSN, 4, 1-based index of the retirement to check; legal range 1..2^CNT_W-1
CNT_W, 8, width of the retirement counter
SETTLE_CYCLES, 2, cycles after reset release before retirements are counted; legal range 1..15
MAX_CYCLES, 64, COUNT-state cycle budget before timeout; legal range 1..65535

Ports:
clk  in  1  single system clock, rising edge
reset_n  in  1  asynchronous active-low reset
z80fi_valid  in  1  one instruction retires this cycle
z80fi_reg_ip_in  in  16  IP at start of the retiring instruction
z80fi_reg_ip_out  in  16  IP after the retiring instruction
checker_reset  out  1  drives the checker's active-high reset
check  out  1  drives the checker's check input
retire_count  out  CNT_W  retirements counted since entering COUNT
done  out  1  target retirement has been checked
timeout  out  1  cycle budget expired before the target retirement
chain_err  out  1  sticky IP discontinuity between consecutive retirements
state  out  3  encoded FSM state, for cover and debug

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=HOLD (0), checker_reset=1, retire_count=0, done=0, timeout=0, chain_err=0
  - settle counter=0, cycle counter=0, have_prev=0, prev_ip=0.
- FSM states: HOLD=0, SETTLE=1, COUNT=2, CHECKED=3, TIMEOUT=4.
- HOLD -> SETTLE on the first clock after reset_n rises. checker_reset stays 1.
- SETTLE:
  - settle counter increments each cycle.
  - When it reaches SETTLE_CYCLES-1, go to COUNT and drop checker_reset to 0 (registered, so it is 0 from the first COUNT cycle).
  - z80fi_valid is ignored in HOLD and SETTLE.
- COUNT:
  - Cycle counter increments each cycle.
  - When z80fi_valid=1, retire_count increments. It saturates at all-ones, which cannot occur before the target given the legal range.
- check is combinational, with zero latency relative to z80fi_valid:
  - check = (state==COUNT) & z80fi_valid & (retire_count==CHECK_INSN-1).
  - It is never asserted in any other state.
- Target retirement (check=1):
  - Next state is CHECKED; done=1 from the next cycle.
  - retire_count still increments, to CHECK_INSN.
- Timeout: if the cycle counter equals MAX_CYCLES-1 and check=0, next state is TIMEOUT and timeout=1 from the next cycle.
- Simultaneous target and timeout in the same cycle: check wins, the FSM goes to CHECKED, and timeout stays 0.
- CHECKED and TIMEOUT are terminal until reset:
  - check=0, checker_reset=0, retire_count frozen.
  - done and timeout are mutually exclusive.
- Chain tracking, COUNT state only:
  - On each valid retirement, if have_prev=1 and z80fi_reg_ip_in != prev_ip, set chain_err=1 (sticky).
  - Every valid retirement then updates prev_ip <= z80fi_reg_ip_out and have_prev <= 1.
  - The first retirement in COUNT is never compared.
  - Wrap-around is compared bit-exactly; no special case for 16'hFFFF -> 16'h0000.
  - The compare also runs on the target retirement, so chain_err may set the same edge done sets.
- Reset asserted mid-operation (any state): all registers return to their reset values immediately. check falls combinationally because state=HOLD.
- Widths: counters compare by equality and never wrap inside their legal range. The cycle counter is 16 bits.

Test Plan:
- Defaults; reset_n released at cycle 0; valid every cycle from cycle 1 -> checker_reset=1 through SETTLE; retire_count counts only from the first COUNT cycle; check high on exactly the 4th counted valid; done=1 the next cycle; retire_count stays 4.
- Valid pulses at COUNT cycles 0, 5, 9, 20 -> check only at cycle 20; retire_count reads 1, 2, 3, 4 after each pulse; no check on the other valid cycles.
- MAX_CYCLES=8; only 2 valids in COUNT -> timeout=1 and state=4 on the 9th cycle; check never asserted; done=0.
- MAX_CYCLES=8; 4th valid lands exactly on COUNT cycle 7 -> check=1; next state CHECKED; timeout=0.
- Sequence ip_in/ip_out = 0000/0001, 0001/0003, 0004/0005 -> chain_err=0 after the 2nd retirement and 1 after the 3rd; it stays 1 through done. Pair FFFF/0000 followed by 0000/0002 -> chain_err stays 0.
- Assert reset_n low in COUNT with retire_count=3, same cycle as a valid -> check=0; all outputs return to reset values. After release the sequence restarts and the 4th new retirement is checked.
